// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the core/memory interface, plus the responder's
// state encoding and byte-lane helpers.
package dbus_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    function automatic logic [63:0] strobe_mask(input logic [7:0] strobe);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{strobe[i]}};
        return m;
    endfunction

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] align_mask(input msize_t size);
        case (size)
            MSIZE1:  return 3'b000;
            MSIZE2:  return 3'b001;
            MSIZE4:  return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/dbus_ram.sv
// Single-port 64-bit word RAM: byte-enable write on the clock, combinational read.
module dbus_ram
    import dbus_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [7:0]    strobe,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];
    logic [63:0] mask;

    assign mask  = strobe_mask(strobe);
    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
    end

endmodule

// File: rtl/dbus_responder.sv
// Slave end of the core data bus backed by dbus_ram, fixed-latency responses.
// Define DBUS_RAND_STALL_EN to add 0-3 pseudo-random wait cycles per request.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err
);

    localparam int          IW   = $clog2(DEPTH);
    localparam int          CW   = $clog2(LATENCY + 4);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    resp_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, extra;
    logic [63:0]   addr_q, wdata_q, hold_q, off, rd_data;
    msize_t        size_q;
    logic [7:0]    strobe_q;
    logic          in_range, misaligned, bad, we;

`ifdef DBUS_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign extra = CW'(lfsr[1:0]);
`else
    assign extra = '0;
`endif

    assign off        = addr_q - BASE;
    assign in_range   = (addr_q >= BASE) && (off < SPAN);
    assign misaligned = |(addr_q[2:0] & align_mask(size_q));
    assign bad        = !in_range || misaligned;
    assign we         = (state == RESP) && !bad && (strobe_q != '0);

    dbus_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
        .clk    (clk),
        .we     (we),
        .idx    (off[IW+2:3]),
        .strobe (strobe_q),
        .wdata  (wdata_q),
        .rdata  (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            size_q   <= MSIZE1;
            strobe_q <= '0;
            wdata_q  <= '0;
            hold_q   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && dreq.valid) begin
                addr_q   <= dreq.addr;
                size_q   <= dreq.size;
                strobe_q <= dreq.strobe;
                wdata_q  <= dreq.data;
            end
            if (state == RESP) hold_q <= dresp.data;
        end
    end

    // The counter holds the remaining wait cycles; the last one hands over to RESP.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (dreq.valid) begin
                cnt_nx   = CW'(LATENCY - 1) + extra;
                state_nx = (cnt_nx == '0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Writes leave the data bus at its previous value; faulted accesses return zero.
    always_comb begin
        dresp      = '0;
        dresp.data = hold_q;
        err        = 1'b0;
        if (state == RESP) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            err           = bad;
            if (bad)                  dresp.data = '0;
            else if (strobe_q == '0)  dresp.data = rd_data;
        end
    end

    a_valid_held: assert property (@(posedge clk) disable iff (!reset)
        (state == WAIT) |-> dreq.valid);

endmodule
